// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared states, speed codes and defaults for the Simon Says controller
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    GEN,
    SETSPD,
    SHOW_ON,
    SHOW_OFF,
    PLAYER,
    WIN,
    LOSE
  } state_e;

  localparam int SPEED_W = 3;
  localparam int ROUND_W = 6;
  localparam int IDX_W   = 5;

  localparam logic [SPEED_W-1:0] SPD_1HZ  = 3'd0;
  localparam logic [SPEED_W-1:0] SPD_2HZ  = 3'd1;
  localparam logic [SPEED_W-1:0] SPD_4HZ  = 3'd2;
  localparam logic [SPEED_W-1:0] SPD_8HZ  = 3'd3;
  localparam logic [SPEED_W-1:0] SPD_16HZ = 3'd4;

  localparam int DEF_MAX_ROUNDS       = 32;
  localparam int DEF_ROUNDS_PER_SPEED = 4;
  localparam int DEF_MAX_SPEED        = int'(SPD_16HZ);
  localparam int DEF_TIMEOUT_PULSES   = 8;

endpackage

// File: rtl/guess_timeout.sv
// rtl/guess_timeout.sv - counts timer pulses while waiting for a guess; flags expiry
module guess_timeout #(
  parameter int TIMEOUT_PULSES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic pulse_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_PULSES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (pulse_i && (cnt_q != CNT_W'(TIMEOUT_PULSES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Expiry is flagged in the same cycle as the final pulse so the loss is not delayed.
  assign expired_o = (cnt_d == CNT_W'(TIMEOUT_PULSES));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - Simon Says sequencing FSM driving the datapath command strobes
module game_controller
  import simon_pkg::*;
#(
  parameter int MAX_ROUNDS       = DEF_MAX_ROUNDS,
  parameter int ROUNDS_PER_SPEED = DEF_ROUNDS_PER_SPEED,
  parameter int MAX_SPEED        = DEF_MAX_SPEED,
  parameter int TIMEOUT_PULSES   = DEF_TIMEOUT_PULSES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_req_i,
  input  logic               pulse_i,
  input  logic               guess_valid_i,
  input  logic               guess_ok_i,
  output logic               rst_seedgen_o,
  output logic               start_o,
  output logic               load_colour_o,
  output logic               load_speed_o,
  output logic [SPEED_W-1:0] speed_o,
  output logic               flash_colour_o,
  output logic               player_turn_o,
  output logic [IDX_W-1:0]   check_round_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               game_over_o,
  output logic               win_o
);

  localparam int SPC_W = $clog2(ROUNDS_PER_SPEED + 1);

  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [SPC_W-1:0]     spd_cnt_q, spd_cnt_d;

  logic rst_seedgen_q, start_q, load_colour_q, load_speed_q;
  logic flash_q, player_q, game_over_q, win_q;

  logic last_idx;
  logic tmo_clear;
  logic tmo_expired;

  // Six-bit compare so round=32 does not alias against a 5-bit index.
  assign last_idx  = ({1'b0, idx_q} == (round_q - ROUND_W'(1)));
  assign tmo_clear = (state_q != PLAYER) || guess_valid_i;

  guess_timeout #(
    .TIMEOUT_PULSES(TIMEOUT_PULSES)
  ) u_guess_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmo_clear),
    .pulse_i   (pulse_i),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    idx_d     = idx_q;
    speed_d   = speed_q;
    spd_cnt_d = spd_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_req_i) state_d = START;
      end
      START: begin
        round_d   = '0;
        speed_d   = SPD_1HZ;
        spd_cnt_d = '0;
        state_d   = GEN;
      end
      GEN: begin
        round_d = round_q + ROUND_W'(1);
        state_d = SETSPD;
      end
      SETSPD: begin
        idx_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (pulse_i) state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (pulse_i) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = PLAYER;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SHOW_ON;
          end
        end
      end
      PLAYER: begin
        if (guess_valid_i) begin
          if (!guess_ok_i) begin
            state_d = LOSE;
          end else if (!last_idx) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (round_q == ROUND_W'(MAX_ROUNDS)) begin
            state_d = WIN;
          end else begin
            if (spd_cnt_q == SPC_W'(ROUNDS_PER_SPEED - 1)) begin
              spd_cnt_d = '0;
              if (speed_q < SPEED_W'(MAX_SPEED)) speed_d = speed_q + SPEED_W'(1);
            end else begin
              spd_cnt_d = spd_cnt_q + SPC_W'(1);
            end
            state_d = GEN;
          end
        end else if (tmo_expired) begin
          state_d = LOSE;
        end
      end
      WIN, LOSE: begin
        if (start_req_i) state_d = START;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each output is a flop aligned with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      round_q       <= '0;
      idx_q         <= '0;
      speed_q       <= '0;
      spd_cnt_q     <= '0;
      rst_seedgen_q <= 1'b1;
      start_q       <= 1'b0;
      load_colour_q <= 1'b0;
      load_speed_q  <= 1'b0;
      flash_q       <= 1'b0;
      player_q      <= 1'b0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      idx_q         <= idx_d;
      speed_q       <= speed_d;
      spd_cnt_q     <= spd_cnt_d;
      rst_seedgen_q <= 1'b0;
      start_q       <= (state_d == START);
      load_colour_q <= (state_d == GEN);
      load_speed_q  <= (state_d == SETSPD);
      flash_q       <= (state_d == SHOW_ON);
      player_q      <= (state_d == PLAYER);
      game_over_q   <= (state_d == WIN) || (state_d == LOSE);
      win_q         <= (state_d == WIN);
    end
  end

  assign rst_seedgen_o  = rst_seedgen_q;
  assign start_o        = start_q;
  assign load_colour_o  = load_colour_q;
  assign load_speed_o   = load_speed_q;
  assign speed_o        = speed_q;
  assign flash_colour_o = flash_q;
  assign player_turn_o  = player_q;
  assign check_round_o  = idx_q;
  assign round_o        = round_q;
  assign game_over_o    = game_over_q;
  assign win_o          = win_q;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - scoreboard bench for the Simon Says game controller
module tb_game_controller;

  localparam int EV_START  = 0;
  localparam int EV_LC     = 1;
  localparam int EV_LS     = 2;
  localparam int EV_FLASH  = 3;
  localparam int EV_PLAYER = 4;
  localparam int EV_OVER   = 5;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t sb[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_req = 1'b0;
  logic pulse = 1'b0;
  logic guess_valid = 1'b0;
  logic guess_ok = 1'b0;

  logic       rst_seedgen_o, start_o, load_colour_o, load_speed_o;
  logic [2:0] speed_o;
  logic       flash_colour_o, player_turn_o;
  logic [4:0] check_round_o;
  logic [5:0] round_o;
  logic       game_over_o, win_o;

  int checks = 0;
  int failures = 0;
  int exp_flash_len = 0;

  game_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start_req_i    (start_req),
    .pulse_i        (pulse),
    .guess_valid_i  (guess_valid),
    .guess_ok_i     (guess_ok),
    .rst_seedgen_o  (rst_seedgen_o),
    .start_o        (start_o),
    .load_colour_o  (load_colour_o),
    .load_speed_o   (load_speed_o),
    .speed_o        (speed_o),
    .flash_colour_o (flash_colour_o),
    .player_turn_o  (player_turn_o),
    .check_round_o  (check_round_o),
    .round_o        (round_o),
    .game_over_o    (game_over_o),
    .win_o          (win_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int spd(input int r);
    int s;
    s = (r - 1) / 4;
    return (s > 4) ? 4 : s;
  endfunction

  function automatic int strobes();
    return int'({start_o, load_colour_o, load_speed_o, flash_colour_o,
                 player_turn_o, game_over_o, win_o});
  endfunction

  // Monitor: pops one expectation per observed DUT event.
  logic prev_flash, prev_player, prev_over;
  int   flash_cnt = 0;

  always @(negedge clk) begin : monitor
    int kind, a, b;
    ev_t e;
    kind = -1;
    a = 0;
    b = 0;
    if (reset) begin
      flash_cnt = 0;
    end else begin
      if (start_o) begin
        kind = EV_START; a = int'(game_over_o); b = int'(win_o);
      end else if (load_colour_o) begin
        kind = EV_LC; a = int'(round_o); b = int'(speed_o);
      end else if (load_speed_o) begin
        kind = EV_LS; a = int'(speed_o); b = int'(round_o);
      end else if (flash_colour_o && !prev_flash) begin
        kind = EV_FLASH; a = int'(check_round_o); b = int'(round_o);
      end else if (player_turn_o && !prev_player) begin
        kind = EV_PLAYER; a = int'(check_round_o); b = int'(round_o);
      end else if (game_over_o && !prev_over) begin
        kind = EV_OVER; a = int'(win_o); b = int'(round_o);
      end
      if (kind >= 0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event kind=%0d a=%0d b=%0d expected none", kind, a, b);
        end else begin
          e = sb.pop_front();
          check($sformatf("ev_kind(exp %0d)", e.kind), kind, e.kind);
          check($sformatf("ev%0d_a", e.kind), a, e.a);
          check($sformatf("ev%0d_b", e.kind), b, e.b);
        end
      end
      if (flash_colour_o) begin
        flash_cnt++;
      end else if (prev_flash) begin
        check("flash_len", flash_cnt, exp_flash_len);
        flash_cnt = 0;
      end
    end
    prev_flash  = flash_colour_o;
    prev_player = player_turn_o;
    prev_over   = game_over_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    sb.push_back('{EV_START, 0, 0});
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic wait_flash();
    int n;
    n = 0;
    while (!flash_colour_o && n < 50) begin
      tick();
      n++;
    end
    check("wait_flash", int'(flash_colour_o), 1);
  endtask

  task automatic play_show(input int r, input int period);
    sb.push_back('{EV_LC, r - 1, spd(r)});
    sb.push_back('{EV_LS, spd(r), r});
    for (int i = 0; i < r; i++) sb.push_back('{EV_FLASH, i, r});
    sb.push_back('{EV_PLAYER, 0, r});
    exp_flash_len = period;
    wait_flash();
    for (int k = 0; k < 2 * r; k++) begin
      repeat (period - 1) tick();
      pulse = 1'b1;
      tick();
      pulse = 1'b0;
    end
  endtask

  task automatic guess(input logic ok);
    guess_valid = 1'b1;
    guess_ok = ok;
    tick();
    guess_valid = 1'b0;
    guess_ok = 1'b0;
  endtask

  task automatic all_guesses(input int r);
    for (int i = 0; i < r; i++) begin
      if (i == r - 1 && r == 32) sb.push_back('{EV_OVER, 1, 32});
      guess(1'b1);
    end
  endtask

  task automatic idle_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      pulse = 1'b1;
      tick();
      pulse = 1'b0;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("reset_seedgen", int'(rst_seedgen_o), 1);
    check("reset_strobes", strobes(), 0);
    check("reset_round", int'(round_o), 0);
    check("reset_speed", int'(speed_o), 0);
    check("reset_check_round", int'(check_round_o), 0);
    reset = 1'b0;
    tick();
    check("idle_seedgen", int'(rst_seedgen_o), 0);

    // Game 1: full 32-round win; first round slow, speed ramps and saturates
    do_start();
    play_show(1, 10);
    check("r1_player_check_round", int'(check_round_o), 0);
    all_guesses(1);
    for (int r = 2; r <= 32; r++) begin
      play_show(r, 2);
      all_guesses(r);
    end
    repeat (20) tick();
    check("win_game_over", int'(game_over_o), 1);
    check("win_flag", int'(win_o), 1);
    check("win_round", int'(round_o), 32);
    check("win_speed_sat", int'(speed_o), 4);

    // Game 2: restart from WIN, lose on second guess of round 3
    do_start();
    play_show(1, 3);
    all_guesses(1);
    play_show(2, 3);
    all_guesses(2);
    play_show(3, 3);
    guess(1'b1);
    check("r3_check_round_after_guess", int'(check_round_o), 1);
    sb.push_back('{EV_OVER, 0, 3});
    guess(1'b0);
    check("lose_player_turn", int'(player_turn_o), 0);
    check("lose_game_over", int'(game_over_o), 1);
    check("lose_win", int'(win_o), 0);
    guess(1'b1);
    repeat (5) tick();
    check("lose_ignores_guess", int'(game_over_o), 1);
    check("lose_round_held", int'(round_o), 3);

    // Game 3: timeout after exactly 8 pulses with no guess
    do_start();
    play_show(1, 3);
    idle_pulses(7);
    check("tmo7_player_turn", int'(player_turn_o), 1);
    check("tmo7_game_over", int'(game_over_o), 0);
    sb.push_back('{EV_OVER, 0, 1});
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    check("tmo8_game_over", int'(game_over_o), 1);
    check("tmo8_win", int'(win_o), 0);

    // Game 4: guess coincident with the 8th pulse wins over the timeout
    do_start();
    play_show(1, 3);
    idle_pulses(7);
    pulse = 1'b1;
    guess_valid = 1'b1;
    guess_ok = 1'b1;
    tick();
    pulse = 1'b0;
    guess_valid = 1'b0;
    guess_ok = 1'b0;
    check("coincide_no_loss", int'(game_over_o), 0);
    play_show(2, 3);
    idle_pulses(7);
    pulse = 1'b1;
    guess(1'b1);
    pulse = 1'b0;
    idle_pulses(7);
    check("tmo_cleared_player_turn", int'(player_turn_o), 1);
    check("tmo_cleared_check_round", int'(check_round_o), 1);
    guess(1'b1);

    // Reset in the middle of round 3 playback
    sb.push_back('{EV_LC, 2, 0});
    sb.push_back('{EV_LS, 0, 3});
    sb.push_back('{EV_FLASH, 0, 3});
    wait_flash();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midreset_strobes", strobes(), 0);
    check("midreset_round", int'(round_o), 0);
    check("midreset_seedgen", int'(rst_seedgen_o), 1);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("post_reset_idle_strobes", strobes(), 0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level sequencing FSM for the Simon Says game.
- Starts a game, orders the seed generator, RNG and segment array to append one colour per round, and sets the flash timer speed.
- Steps the colour playback on timer pulses, then hands control to the player and advances through guesses using the checker's verdict.
- Sits between the datapath blocks (seed register, RNG, segment array, variable timer, colour flasher, input verifier) and owns every command strobe they receive.

Parameters:
MAX_ROUNDS, 32, sequence length that wins the game (1..32)
ROUNDS_PER_SPEED, 4, rounds completed before speed code increments
MAX_SPEED, 4, saturation value of speed code (4 = 16 Hz)
TIMEOUT_PULSES, 8, timer pulses allowed per guess before loss

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
start_req  in  1  one-cycle start strobe from debounced key
pulse  in  1  one-cycle tick from variable timer
guess_valid  in  1  one-cycle strobe: player committed a guess
guess_ok  in  1  checker verdict for segment[check_round]; sampled only with guess_valid
rst_seedgen  out  1  holds seed generator in reset
start  out  1  one-cycle: RNG loads current seed
load_colour  out  1  one-cycle: segment array appends RNG output
load_speed  out  1  one-cycle: timer reloads from speed
speed  out  3  timer speed code 0..MAX_SPEED
flash_colour  out  1  colour flasher shows segment[check_round]
player_turn  out  1  player input enabled
check_round  out  5  index into segment array
round  out  6  colours in current sequence (0..32)
game_over  out  1  game ended (win or loss)
win  out  1  valid only when game_over=1

Behaviour:
- Reset (any state, any cycle): state IDLE; all outputs 0 except rst_seedgen=1 for that cycle; round, idx, speed, spd_cnt, tmo_cnt cleared.
- IDLE: rst_seedgen=0 so the seed free-runs. On start_req go to START.
- START (1 cycle):
  - start=1; round<=0, speed<=0, spd_cnt<=0; clear game_over and win.
  - Go to GEN.
- GEN (1 cycle):
  - load_colour=1; round<=round+1.
  - Go to SETSPD.
- SETSPD (1 cycle):
  - load_speed=1 with the registered speed; idx<=0.
  - Any pulse arriving in this cycle is ignored.
  - Go to SHOW_ON.
- SHOW_ON:
  - flash_colour=1, check_round=idx.
  - On pulse go to SHOW_OFF.
- SHOW_OFF:
  - flash_colour=0.
  - On pulse: if idx==round-1, then idx<=0, tmo_cnt<=0, go to PLAYER; else idx<=idx+1, go to SHOW_ON.
- PLAYER:
  - player_turn=1, check_round=idx.
  - guess_valid & !guess_ok -> LOSE.
  - guess_valid & guess_ok & idx<round-1 -> idx++, tmo_cnt<=0.
  - guess_valid & guess_ok & idx==round-1 & round==MAX_ROUNDS -> WIN.
  - guess_valid & guess_ok & idx==round-1 & round<MAX_ROUNDS -> speed update, then GEN.
  - Speed update: spd_cnt++; when spd_cnt reaches ROUNDS_PER_SPEED-1 it wraps to 0 and speed<=min(speed+1, MAX_SPEED).
  - pulse without guess_valid -> tmo_cnt++; when tmo_cnt reaches TIMEOUT_PULSES -> LOSE.
  - guess_valid and pulse in the same cycle: the guess takes priority and the pulse is not counted.
- WIN: game_over=1, win=1. LOSE: game_over=1, win=0.
  - Both hold until start_req, which goes to START (restart).
- start_req is ignored in every state other than IDLE, WIN and LOSE.
- guess_valid is ignored outside PLAYER.
- Outputs are registered Moore outputs; strobes are exactly one cycle wide.
- Latency from start_req to the first flash_colour is 4 cycles (START, GEN, SETSPD, then SHOW_ON).
- Arithmetic widths:
  - round is 6-bit, idx is 5-bit.
  - Compare idx against round-1 on 6 bits so round=32 does not alias.
  - tmo_cnt is $clog2(TIMEOUT_PULSES+1) bits.

Decomposition:
- Package simon_pkg:
  - state enum (IDLE, START, GEN, SETSPD, SHOW_ON, SHOW_OFF, PLAYER, WIN, LOSE).
  - Speed code constants SPD_1HZ..SPD_16HZ.
  - Parameter defaults.
- Sub-module guess_timeout:
  - Counts pulses, clears on guess_valid or on entry to PLAYER, outputs expired.
  - Instantiated once.

Test Plan:
- Reset, then start_req -> start at cycle 1, load_colour at cycle 2, load_speed at cycle 3 with speed=0, round=1, flash_colour=1 with check_round=0.
- Round 1 playback with pulse every 10 cycles -> flash_colour high 10 cycles then low 10 cycles; player_turn=1, check_round=0; guess_valid&guess_ok -> load_colour strobe, round=2.
- Clear 4 rounds correctly -> speed becomes 1 on the 5th load_speed; after 16 rounds speed saturates at 4 and never reaches 5.
- Round 3, second guess with guess_ok=0 -> game_over=1, win=0; player_turn drops next cycle; a later guess_valid is ignored; start_req restarts with round=1.
- In PLAYER, 8 pulses with no guess -> LOSE; guess_valid coincident with the 8th pulse -> no loss, tmo_cnt cleared.
- Run MAX_ROUNDS=32 all correct -> win=1, round=32, no 33rd load_colour; reset asserted mid-playback -> IDLE with all strobes 0 on the next cycle.
